// File: rtl/mc_exec_core.sv
// mc_exec_core
//   Per-core execution unit. Accepts one operation through a start_op/ready
//   handshake and runs ALU ops, an iterative shift-add multiply, a rotate, or
//   a scratchpad store/load. Returns a 2*WIDTH result with a one-cycle end_op.
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   A, B       operands (WIDTH)
//   start_op   request; accepted on an edge where start_op=1 and ready=1
//   op_sel     opcode (4 bits), sampled at acceptance
//   address_in scratchpad address for ST/LD (ADDR_W)
//   data_in    store data for ST (WIDTH)
//   ready      idle, can accept an op this cycle
//   end_op     one-cycle completion pulse; result/err valid
//   result     operation result (2*WIDTH), held until the next end_op
//   err        illegal opcode or scratchpad address out of range
module mc_exec_core #(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 12,
    parameter int MEM_WORDS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 start_op,
    input  logic [3:0]           op_sel,
    input  logic [ADDR_W-1:0]    address_in,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 ready,
    output logic                 end_op,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
);

    localparam int CW = $clog2(WIDTH);
    localparam int MW = $clog2(MEM_WORDS);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_ROL = 4'd6;
    localparam logic [3:0] OP_ST  = 4'd7;
    localparam logic [3:0] OP_LD  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_q, b_q, data_q;
    logic [3:0]         op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mem [MEM_WORDS];

    logic               accept;
    logic [2*WIDTH-1:0] exec_res;
    logic               exec_err;
    logic               exec_we;
    logic               addr_ok;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [2*WIDTH-1:0] rot_w;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        end_op    = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                ready  = 1'b1;
                accept = start_op;
                if (start_op) state_nxt = (op_sel == OP_MUL) ? S_MUL : S_EXEC;
            end
            S_EXEC: state_nxt = S_DONE;
            S_MUL:  if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE: begin
                ready  = 1'b1;
                end_op = 1'b1;
                accept = start_op;
                if (start_op) state_nxt = (op_sel == OP_MUL) ? S_MUL : S_EXEC;
                else          state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        addr_ok  = ({1'b0, addr_q} < MEM_LIMIT);
        sum_w    = {1'b0, a_q} + {1'b0, b_q};
        // Bit WIDTH of the widened difference is the borrow.
        diff_w   = {1'b0, a_q} - {1'b0, b_q};
        // Upper half of the doubled operand shifted left is the rotation.
        rot_w    = {a_q, a_q} << b_q[CW-1:0];
        exec_res = '0;
        exec_err = 1'b0;
        exec_we  = 1'b0;
        case (op_q)
            OP_ADD: exec_res = {{(WIDTH-1){1'b0}}, sum_w};
            OP_SUB: exec_res = {{(WIDTH-1){1'b0}}, diff_w};
            OP_AND: exec_res = {{WIDTH{1'b0}}, a_q & b_q};
            OP_OR:  exec_res = {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR: exec_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_ROL: exec_res = {{WIDTH{1'b0}}, rot_w[2*WIDTH-1:WIDTH]};
            OP_ST: begin
                exec_err = !addr_ok;
                exec_we  = addr_ok;
            end
            OP_LD: begin
                exec_err = !addr_ok;
                if (addr_ok) exec_res = {{WIDTH{1'b0}}, mem[addr_q[MW-1:0]]};
            end
            default: exec_err = 1'b1;
        endcase
    end

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
            op_q   <= '0;
            addr_q <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
            for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                a_q    <= A;
                b_q    <= B;
                data_q <= data_in;
                op_q   <= op_sel;
                addr_q <= address_in;
                mcand  <= {{WIDTH{1'b0}}, A};
                mplier <= B;
                acc    <= '0;
                cnt    <= '0;
            end
            case (state)
                S_EXEC: begin
                    result <= exec_res;
                    err    <= exec_err;
                    if (exec_we) mem[addr_q[MW-1:0]] <= data_q;
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        result <= acc_nxt;
                        err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
